// File: rtl/piso_pkg.sv
// Shared types and default sizing for the LED-chain serializer.
// Default prescaler gives a visibly slow shift clock on the board.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 4;
  localparam int DIV_W_DEF = 23;

endpackage

// File: rtl/piso_serializer_tick_gen.sv
// Free-running prescaler: one-cycle tick whenever the counter is zero, every 2**DIV_W clocks.
// Tick is combinational from the count; the first tick is the first cycle after reset release.
module tick_gen #(
  parameter int DIV_W = 23
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  assign cnt_d = cnt_q + DIV_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Word-in, LSB-first bit-out serializer; one bit per tick, first bit 1..2**DIV_W cycles after accept.
// load_ready only in IDLE; loads offered while busy are dropped, optional back-to-back repeat.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             repeat_en,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic             tick
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] shreg_q,   shreg_d;
  logic [WIDTH-1:0] saved_q,   saved_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             serial_q,  serial_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;

  tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    saved_d   = saved_q;
    bit_cnt_d = bit_cnt_q;
    serial_d  = serial_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // A tick coinciding with the accept is deliberately not used to start.
        if (load_valid) begin
          shreg_d   = load_data;
          saved_d   = load_data;
          bit_cnt_d = '0;
          state_d   = ARMED;
        end
      end
      ARMED: begin
        if (tick) begin
          serial_d  = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = CW'(1);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bit_cnt_q < LAST_CNT) begin
            serial_d  = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + CW'(1);
          end else begin
            done_d = 1'b1;
            if (repeat_en) begin
              serial_d  = saved_q[0];
              shreg_d   = saved_q >> 1;
              bit_cnt_d = CW'(1);
            end else begin
              serial_d = 1'b0;
              state_d  = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      saved_q   <= '0;
      bit_cnt_q <= '0;
      serial_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      saved_q   <= saved_d;
      bit_cnt_q <= bit_cnt_d;
      serial_q  <= serial_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized bench for piso_serializer with a tick-level bit-queue reference model and a paired receiver.
module tb_piso_serializer;

  localparam int WIDTH = 4;
  localparam int DIV_W = 3;
  localparam int TPER  = 1 << DIV_W;

  logic             clk;
  logic             reset_n;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             repeat_en;
  logic             serial_out;
  logic             busy;
  logic             done;
  logic             tick;

  int vec_cnt = 0;
  int err_cnt = 0;
  bit chk_en  = 0;

  piso_serializer #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .repeat_en  (repeat_en),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done),
    .tick       (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: time since reset decides tick; an accepted word becomes a queue of
  // bits that each tick pops, and an empty queue on a tick marks the end of the frame.
  int               m_t;
  bit               m_act;
  logic [WIDTH-1:0] m_word;
  bit               m_q[$];
  logic             e_ser;
  logic             e_done;

  function automatic void fill_queue(input logic [WIDTH-1:0] w);
    m_q.delete();
    for (int i = 0; i < WIDTH; i++) m_q.push_back(w[i]);
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_t    = 0;
      m_act  = 0;
      m_word = '0;
      m_q.delete();
      e_ser  = 1'b0;
      e_done = 1'b0;
    end else begin
      e_done = 1'b0;
      if ((m_t % TPER) == 0 && m_act) begin
        if (m_q.size() > 0) begin
          e_ser = m_q.pop_front();
        end else begin
          e_done = 1'b1;
          if (repeat_en) begin
            fill_queue(m_word);
            e_ser = m_q.pop_front();
          end else begin
            e_ser = 1'b0;
            m_act = 0;
          end
        end
      end else if (!m_act && load_valid) begin
        m_act  = 1;
        m_word = load_data;
        fill_queue(load_data);
      end
      m_t++;
    end
  end

  // Paired receiver: shifts right on the exported tick, new bit entering at the MSB.
  logic [WIDTH-1:0] rx_q;
  always @(posedge clk) begin
    if (tick === 1'b1) rx_q <= {serial_out, rx_q[WIDTH-1:1]};
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("serial_out", 32'(serial_out), 32'(e_ser));
      check_eq("done",       32'(done),       32'(e_done));
      check_eq("busy",       32'(busy),       32'(m_act));
      check_eq("load_ready", 32'(load_ready), 32'(!m_act));
      check_eq("tick",       32'(tick),       32'((m_t % TPER) == 0));
      if (e_done === 1'b1) check_eq("rx_word", 32'(rx_q), 32'(m_word));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (load_ready === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check_eq("ready_wait", 32'(ok), 32'd1);
    load_valid = 1'b1;
    load_data  = w;
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = WIDTH'($urandom);
  endtask

  task automatic wait_done(input int lim);
    bit seen = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check_eq("done_wait", 32'(seen), 32'd1);
  endtask

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 2 * TPER; i++) begin
      @(negedge clk);
      if (tick === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check_eq("tick_wait", 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input int lim);
    bit seen = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (load_ready === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check_eq("idle_wait", 32'(seen), 32'd1);
  endtask

  initial begin
    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    repeat_en  = 1'b0;
    step(3);
    chk_en  = 1;
    reset_n = 1'b1;
    step(3 * TPER);

    // Single frame, accepted off a tick.
    step($urandom_range(1, 5));
    send(4'b1011);
    wait_done(6 * TPER);
    step(5);

    // Accept in the same cycle as a tick: first bit waits a full period.
    wait_tick();
    send(4'b1101);
    wait_done(6 * TPER);
    step(3);

    // A load offered mid-frame must be dropped.
    send(4'b1001);
    step(12);
    load_valid = 1'b1;
    load_data  = 4'b0110;
    step(1);
    load_valid = 1'b0;
    wait_done(6 * TPER);
    step(2 * TPER);

    // Continuous retransmission until repeat_en drops.
    repeat_en = 1'b1;
    send(4'b0001);
    step(100);
    repeat_en = 1'b0;
    wait_idle(8 * TPER);
    step(4);

    // Reset pulse just after the second bit, then a fresh frame.
    send(WIDTH'($urandom));
    wait_tick();
    wait_tick();
    step(1);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step($urandom_range(0, 9));
    send(WIDTH'($urandom));
    wait_done(6 * TPER);

    // Random frames with load noise and occasional repeats.
    for (int f = 0; f < 12; f++) begin
      step($urandom_range(0, 12));
      repeat_en = ($urandom_range(0, 3) == 0);
      send(WIDTH'($urandom));
      for (int c = 0; c < 40; c++) begin
        load_valid = ($urandom_range(0, 7) == 0);
        load_data  = WIDTH'($urandom);
        step(1);
      end
      load_valid = 1'b0;
      repeat_en  = 1'b0;
      wait_idle(8 * TPER);
    end
    step(5);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
